quad_encoder_gen: RTL and testbench

- Quadrature encoder emulator: converts a signed RPM command into enc_a/enc_b quadrature waveforms and a signed position count.
- Encoding matches the RPM reader's decoding: same 408 PPR, x4 edges, and the same 10 MHz constant K = 367647.
- Drives the PID loop in hardware-in-the-loop tests without a motor; optionally mirrors a commanded speed to an external encoder input.

---
 rtl/quad_encoder_gen_pkg.sv | 34 +++
 rtl/quad_encoder_gen_if.sv | 11 +
 rtl/quad_encoder_gen_seq_divider.sv | 53 +++++
 rtl/quad_encoder_gen.sv | 126 ++++++++++++
 tb/tb_quad_encoder_gen.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/quad_encoder_gen_pkg.sv
// rtl/quad_encoder_gen_pkg.sv - shared constants, phase encoding and FSM states for the quadrature encoder emulator
package quad_encoder_gen_pkg;

  localparam int CLK_FREQ         = 10_000_000;
  localparam int PPR              = 408;
  localparam int EDGES_PER_REV    = PPR * 4;
  localparam int PERIOD_K_DEFAULT = CLK_FREQ * 60 / EDGES_PER_REV;
  localparam int DIV_STEPS        = 32;

  // {A,B} levels; forward order is 00 -> 10 -> 11 -> 01
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_LOAD = 2'd2
  } cmd_state_t;

  function automatic logic [1:0] next_phase(input logic [1:0] ab, input logic rev);
    logic [1:0] nxt;
    nxt = PH_00;
    case (ab)
      PH_00:   nxt = rev ? PH_01 : PH_10;
      PH_10:   nxt = rev ? PH_00 : PH_11;
      PH_11:   nxt = rev ? PH_10 : PH_01;
      default: nxt = rev ? PH_11 : PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_encoder_gen_if.sv
// rtl/quad_encoder_gen_if.sv - RPM command handshake bundle
interface quad_encoder_gen_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         cmd_valid_i;
  logic                         cmd_ready_o;
  logic signed [DATA_WIDTH-1:0] cmd_rpm_i;

  modport master (output cmd_valid_i, output cmd_rpm_i, input cmd_ready_o);
  modport slave  (input cmd_valid_i, input cmd_rpm_i, output cmd_ready_o);
endinterface

// File: rtl/quad_encoder_gen_seq_divider.sv
// rtl/quad_encoder_gen_seq_divider.sv - unsigned restoring divider, 32-bit dividend, one quotient bit per clock
module quad_encoder_gen_seq_divider
  import quad_encoder_gen_pkg::*;
#(
  parameter int DIVISOR_WIDTH = 17
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [31:0]              dividend,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic                     done,
  output logic [31:0]              quotient
);

  localparam int CW = $clog2(DIV_STEPS + 1);

  logic [31:0]              quo;
  logic [DIVISOR_WIDTH-1:0] rem;
  logic [DIVISOR_WIDTH-1:0] dvs;
  logic [CW-1:0]            cnt;
  logic [DIVISOR_WIDTH:0]   shifted;
  logic [DIVISOR_WIDTH+1:0] trial;

  // extra top bit of trial is the borrow: set means the divisor did not fit
  assign shifted  = {rem, quo[31]};
  assign trial    = {1'b0, shifted} - {2'b00, dvs};
  assign quotient = quo;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo <= dividend;
        rem <= '0;
        dvs <= divisor;
        cnt <= CW'(DIV_STEPS);
      end else if (cnt != '0) begin
        quo <= {quo[30:0], ~trial[DIVISOR_WIDTH+1]};
        rem <= trial[DIVISOR_WIDTH+1] ? shifted[DIVISOR_WIDTH-1:0] : trial[DIVISOR_WIDTH-1:0];
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_encoder_gen.sv
// rtl/quad_encoder_gen.sv - RPM command to quadrature A/B waveform and signed edge position
module quad_encoder_gen
  import quad_encoder_gen_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int PERIOD_K     = 367647,
  parameter int PERIOD_WIDTH = 20
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable_i,
  quad_encoder_gen_if.slave  cmd,
  output logic               enc_a_o,
  output logic               enc_b_o,
  output logic signed [31:0] pos_o,
  output logic               running_o
);

  localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;

  cmd_state_t              state, state_nxt;
  logic                    cmd_fire, cmd_dir;
  logic [DATA_WIDTH:0]     rpm_ext, cmd_mag;
  logic                    div_start, div_done, shadow_we;
  logic [31:0]             div_q;
  logic [PERIOD_WIDTH-1:0] clamped, load_period;
  logic [PERIOD_WIDTH-1:0] shadow_period, active_period, cnt;
  logic                    shadow_dir, active_dir, terminal, step_rev;

  assign cmd.cmd_ready_o = (state == ST_IDLE);
  assign cmd_fire        = cmd.cmd_valid_i && cmd.cmd_ready_o;
  assign rpm_ext         = {cmd.cmd_rpm_i[DATA_WIDTH-1], cmd.cmd_rpm_i};
  assign cmd_mag         = rpm_ext[DATA_WIDTH] ? (~rpm_ext + 1'b1) : rpm_ext;

  quad_encoder_gen_seq_divider #(.DIVISOR_WIDTH(DATA_WIDTH + 1)) u_div (
    .clk      (clk),
    .rstn     (rstn),
    .start    (div_start),
    .dividend (32'(PERIOD_K)),
    .divisor  (cmd_mag),
    .done     (div_done),
    .quotient (div_q)
  );

  always_comb begin
    clamped = div_q[PERIOD_WIDTH-1:0];
    if (div_q == '0) clamped = PERIOD_WIDTH'(1);
    else if (div_q > 32'(PERIOD_MAX)) clamped = PERIOD_MAX;
  end

  // the quotient is written straight from DIV on done; LOAD only serves the zero-speed path
  always_comb begin
    state_nxt   = state;
    div_start   = 1'b0;
    shadow_we   = 1'b0;
    load_period = '0;
    case (state)
      ST_IDLE: if (cmd_fire) begin
        if (cmd_mag == '0) state_nxt = ST_LOAD;
        else begin
          state_nxt = ST_DIV;
          div_start = 1'b1;
        end
      end
      ST_DIV: if (div_done) begin
        state_nxt   = ST_IDLE;
        shadow_we   = 1'b1;
        load_period = clamped;
      end
      ST_LOAD: begin
        state_nxt = ST_IDLE;
        shadow_we = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      cmd_dir <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_fire) cmd_dir <= cmd.cmd_rpm_i[DATA_WIDTH-1];
    end
  end

  // a stop command keeps the running direction for the final step
  assign terminal  = (cnt == active_period - 1'b1);
  assign step_rev  = (shadow_period != '0) ? shadow_dir : active_dir;
  assign running_o = (active_period != '0) && enable_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_period <= '0;
      shadow_dir    <= 1'b0;
      active_period <= '0;
      active_dir    <= 1'b0;
      cnt           <= '0;
      enc_a_o       <= 1'b0;
      enc_b_o       <= 1'b0;
      pos_o         <= '0;
    end else begin
      if (shadow_we) begin
        shadow_period <= load_period;
        shadow_dir    <= cmd_dir;
      end
      if (active_period == '0) begin
        active_period <= shadow_period;
        active_dir    <= shadow_dir;
        cnt           <= '0;
      end else if (enable_i) begin
        if (terminal) begin
          cnt                <= '0;
          active_period      <= shadow_period;
          active_dir         <= shadow_dir;
          {enc_a_o, enc_b_o} <= next_phase({enc_a_o, enc_b_o}, step_rev);
          pos_o              <= step_rev ? pos_o - 32'sd1 : pos_o + 32'sd1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// tb/tb_quad_encoder_gen.sv - randomized self-checking bench for quad_encoder_gen
module tb_quad_encoder_gen;

  localparam int DW   = 16;
  localparam int K    = 367647;
  localparam int PW   = 20;
  localparam int PMAX = (1 << PW) - 1;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               enable = 1'b0;
  logic               enc_a, enc_b, running;
  logic signed [31:0] pos;

  quad_encoder_gen_if #(.DATA_WIDTH(DW)) cmd_if ();

  quad_encoder_gen #(.DATA_WIDTH(DW), .PERIOD_K(K), .PERIOD_WIDTH(PW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable_i  (enable),
    .cmd       (cmd_if.slave),
    .enc_a_o   (enc_a),
    .enc_b_o   (enc_b),
    .pos_o     (pos),
    .running_o (running)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] m_ab = 2'b00;
  int         m_pos = 0;
  int         last_edge = 0;
  int         cur_p = 0;
  bit         cur_dir = 0;

  function automatic logic [1:0] step_ab(input logic [1:0] ab, input bit rev);
    logic [1:0] ring [4];
    int idx;
    ring = '{2'b00, 2'b10, 2'b11, 2'b01};
    idx = 0;
    for (int i = 0; i < 4; i++) if (ring[i] == ab) idx = i;
    return ring[rev ? (idx + 3) % 4 : (idx + 1) % 4];
  endfunction

  function automatic int exp_period(input int rpm);
    int mag, q;
    mag = (rpm < 0) ? -rpm : rpm;
    if (mag == 0) return 0;
    q = K / mag;
    if (q < 1) q = 1;
    if (q > PMAX) q = PMAX;
    return q;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic get_edge(input int budget, output int t, output logic [1:0] ab, output bit ok);
    logic [1:0] start;
    start = {enc_a, enc_b};
    ok = 0;
    t = -1;
    ab = start;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if ({enc_a, enc_b} !== start) begin
        ok = 1;
        t = cyc;
        ab = {enc_a, enc_b};
      end
    end
  endtask

  task automatic send(input int rpm, output int n);
    int guard;
    guard = 0;
    while (cmd_if.cmd_ready_o !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (guard >= 100) begin
      n_fail++;
      $display("FAIL send_ready_timeout: ready=%b after %0d cycles, want 1", cmd_if.cmd_ready_o, guard);
    end
    cmd_if.cmd_valid_i = 1'b1;
    cmd_if.cmd_rpm_i   = DW'(rpm);
    @(negedge clk);
    n = cyc;
    cmd_if.cmd_valid_i = 1'b0;
    cmd_if.cmd_rpm_i   = '0;
  endtask

  task automatic test_reset();
    int t;
    logic [1:0] ab;
    bit ok;
    rstn = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({enc_a, enc_b} !== 2'b00) begin n_fail++; $display("FAIL rst_ab: got %b want 00", {enc_a, enc_b}); end
    n_checks++; if (pos !== 32'sd0) begin n_fail++; $display("FAIL rst_pos: got %0d want 0", pos); end
    n_checks++; if (cmd_if.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", cmd_if.cmd_ready_o); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL rst_running: got %b want 0", running); end
    rstn = 1'b1;
    enable = 1'b1;
    get_edge(1000, t, ab, ok);
    n_checks++; if (ok) begin n_fail++; $display("FAIL rst_idle_edge: edge at %0d, want none", t); end
    n_checks++; if (pos !== 32'sd0) begin n_fail++; $display("FAIL rst_idle_pos: got %0d want 0", pos); end
  endtask

  task automatic test_forward();
    int n, t, t_exp, p;
    logic [1:0] ab;
    bit ok;
    p = exp_period(1000);
    send(1000, n);
    wait_until(n + 1);
    n_checks++; if (cmd_if.cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL fwd_ready_n1: got %b want 0", cmd_if.cmd_ready_o); end
    wait_until(n + 32);
    n_checks++; if (cmd_if.cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL fwd_ready_n32: got %b want 0", cmd_if.cmd_ready_o); end
    wait_until(n + 33);
    n_checks++; if (cmd_if.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL fwd_ready_n33: got %b want 1", cmd_if.cmd_ready_o); end
    t_exp = n + 34 + p;
    for (int k = 0; k < 4; k++) begin
      get_edge(2 * p + 100, t, ab, ok);
      m_ab = step_ab(m_ab, 1'b0);
      m_pos++;
      n_checks++; if (!ok || t != t_exp) begin n_fail++; $display("FAIL fwd_time%0d: got %0d want %0d", k, t, t_exp); end
      n_checks++; if (ab !== m_ab) begin n_fail++; $display("FAIL fwd_ab%0d: got %b want %b", k, ab, m_ab); end
      n_checks++; if (pos !== 32'(m_pos)) begin n_fail++; $display("FAIL fwd_pos%0d: got %0d want %0d", k, pos, m_pos); end
      t_exp += p;
      last_edge = t;
    end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL fwd_running: got %b want 1", running); end
    cur_p = p;
    cur_dir = 1'b0;
  endtask

  task automatic test_reverse();
    int n, t, t_exp, p;
    logic [1:0] ab;
    bit ok;
    p = exp_period(-1000);
    t_exp = last_edge + cur_p;
    send(-1000, n);
    for (int k = 0; k < 4; k++) begin
      get_edge(2 * p + 100, t, ab, ok);
      m_ab = step_ab(m_ab, 1'b1);
      m_pos--;
      n_checks++; if (!ok || t != t_exp) begin n_fail++; $display("FAIL rev_time%0d: got %0d want %0d", k, t, t_exp); end
      n_checks++; if (ab !== m_ab) begin n_fail++; $display("FAIL rev_ab%0d: got %b want %b", k, ab, m_ab); end
      n_checks++; if (pos !== 32'(m_pos)) begin n_fail++; $display("FAIL rev_pos%0d: got %0d want %0d", k, pos, m_pos); end
      t_exp += p;
      last_edge = t;
    end
    cur_p = p;
    cur_dir = 1'b1;
  endtask

  task automatic test_boundary();
    int n, t, t_exp, p, d;
    logic [1:0] ab;
    bit ok;
    p = exp_period(-500);
    d = $urandom_range(5, 290);
    wait_until(last_edge + d);
    t_exp = last_edge + cur_p;
    send(-500, n);
    for (int k = 0; k < 3; k++) begin
      get_edge(2 * p + 100, t, ab, ok);
      m_ab = step_ab(m_ab, 1'b1);
      m_pos--;
      n_checks++; if (!ok || t != t_exp) begin n_fail++; $display("FAIL bnd_time%0d: got %0d want %0d", k, t, t_exp); end
      n_checks++; if (ab !== m_ab) begin n_fail++; $display("FAIL bnd_ab%0d: got %b want %b", k, ab, m_ab); end
      n_checks++; if (pos !== 32'(m_pos)) begin n_fail++; $display("FAIL bnd_pos%0d: got %0d want %0d", k, pos, m_pos); end
      t_exp = t_exp + p;
      last_edge = t;
    end
    cur_p = p;
    cur_dir = 1'b1;
  endtask

  task automatic test_random();
    int n, t, t_exp, p, rpm;
    logic [1:0] ab;
    bit ok, rev;
    for (int it = 0; it < 4; it++) begin
      rpm = $urandom_range(1000, 10000);
      rev = $urandom_range(0, 1);
      if (rev) rpm = -rpm;
      p = exp_period(rpm);
      t_exp = last_edge + cur_p;
      send(rpm, n);
      for (int k = 0; k < 2; k++) begin
        get_edge(2 * cur_p + 2 * p + 100, t, ab, ok);
        m_ab = step_ab(m_ab, rev);
        m_pos = rev ? m_pos - 1 : m_pos + 1;
        n_checks++; if (!ok || t != t_exp) begin n_fail++; $display("FAIL rnd%0d_time%0d rpm %0d: got %0d want %0d", it, k, rpm, t, t_exp); end
        n_checks++; if (ab !== m_ab) begin n_fail++; $display("FAIL rnd%0d_ab%0d: got %b want %b", it, k, ab, m_ab); end
        n_checks++; if (pos !== 32'(m_pos)) begin n_fail++; $display("FAIL rnd%0d_pos%0d: got %0d want %0d", it, k, pos, m_pos); end
        t_exp = t_exp + p;
        last_edge = t;
      end
      cur_p = p;
      cur_dir = rev;
    end
  endtask

  task automatic test_stop();
    int n, t, t_exp;
    logic [1:0] ab;
    bit ok;
    t_exp = last_edge + cur_p;
    send(0, n);
    get_edge(2 * cur_p + 100, t, ab, ok);
    m_ab = step_ab(m_ab, cur_dir);
    m_pos = cur_dir ? m_pos - 1 : m_pos + 1;
    n_checks++; if (!ok || t != t_exp) begin n_fail++; $display("FAIL stop_last_time: got %0d want %0d", t, t_exp); end
    n_checks++; if (ab !== m_ab) begin n_fail++; $display("FAIL stop_last_ab: got %b want %b", ab, m_ab); end
    @(negedge clk);
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL stop_running: got %b want 0", running); end
    get_edge(1000, t, ab, ok);
    n_checks++; if (ok) begin n_fail++; $display("FAIL stop_hold_edge: edge at %0d, want none", t); end
    n_checks++; if ({enc_a, enc_b} !== m_ab) begin n_fail++; $display("FAIL stop_hold_ab: got %b want %b", {enc_a, enc_b}, m_ab); end
    n_checks++; if (pos !== 32'(m_pos)) begin n_fail++; $display("FAIL stop_hold_pos: got %0d want %0d", pos, m_pos); end
  endtask

  task automatic test_enable();
    int n, t, t_exp, p, d;
    logic [1:0] ab;
    bit ok;
    p = exp_period(1000);
    send(1000, n);
    t_exp = n + 34 + p;
    get_edge(2 * p + 100, t, ab, ok);
    m_ab = step_ab(m_ab, 1'b0);
    m_pos++;
    n_checks++; if (!ok || t != t_exp) begin n_fail++; $display("FAIL en_first_time: got %0d want %0d", t, t_exp); end
    n_checks++; if (ab !== m_ab) begin n_fail++; $display("FAIL en_first_ab: got %b want %b", ab, m_ab); end
    d = $urandom_range(20, 300);
    wait_until(t_exp + d);
    enable = 1'b0;
    wait_until(t_exp + d + 50);
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL en_off_running: got %b want 0", running); end
    wait_until(t_exp + d + 100);
    n_checks++; if (pos !== 32'(m_pos)) begin n_fail++; $display("FAIL en_off_pos: got %0d want %0d", pos, m_pos); end
    enable = 1'b1;
    t_exp = t_exp + p + 100;
    get_edge(2 * p + 100, t, ab, ok);
    m_ab = step_ab(m_ab, 1'b0);
    m_pos++;
    n_checks++; if (!ok || t != t_exp) begin n_fail++; $display("FAIL en_resume_time: got %0d want %0d", t, t_exp); end
    n_checks++; if (ab !== m_ab) begin n_fail++; $display("FAIL en_resume_ab: got %b want %b", ab, m_ab); end
    n_checks++; if (pos !== 32'(m_pos)) begin n_fail++; $display("FAIL en_resume_pos: got %0d want %0d", pos, m_pos); end
    last_edge = t;
    cur_p = p;
    cur_dir = 1'b0;
  endtask

  task automatic test_reset_mid_div();
    int n, t;
    logic [1:0] ab;
    bit ok;
    send(2000, n);
    wait_until(n + 10);
    rstn = 1'b0;
    #1;
    n_checks++; if (cmd_if.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL mrst_ready: got %b want 1", cmd_if.cmd_ready_o); end
    n_checks++; if ({enc_a, enc_b, running} !== 3'b000) begin n_fail++; $display("FAIL mrst_outs: got %b want 000", {enc_a, enc_b, running}); end
    n_checks++; if (pos !== 32'sd0) begin n_fail++; $display("FAIL mrst_pos: got %0d want 0", pos); end
    n_checks++; if (dut.shadow_period !== '0 || dut.active_period !== '0) begin n_fail++; $display("FAIL mrst_periods: got %0d/%0d want 0/0", dut.shadow_period, dut.active_period); end
    @(negedge clk);
    rstn = 1'b1;
    m_ab = 2'b00;
    m_pos = 0;
    get_edge(1000, t, ab, ok);
    n_checks++; if (ok) begin n_fail++; $display("FAIL mrst_no_edge: edge at %0d, want none", t); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL mrst_running: got %b want 0", running); end
  endtask

  task automatic test_extreme();
    int n, n2, t, t_exp, p;
    logic [1:0] ab;
    bit ok;
    p = exp_period(-32768);
    send(-32768, n);
    t_exp = n + 34 + p;
    for (int k = 0; k < 3; k++) begin
      get_edge(200, t, ab, ok);
      m_ab = step_ab(m_ab, 1'b1);
      m_pos--;
      n_checks++; if (!ok || t != t_exp) begin n_fail++; $display("FAIL ext_time%0d: got %0d want %0d", k, t, t_exp); end
      n_checks++; if (ab !== m_ab) begin n_fail++; $display("FAIL ext_ab%0d: got %b want %b", k, ab, m_ab); end
      n_checks++; if (pos !== 32'(m_pos)) begin n_fail++; $display("FAIL ext_pos%0d: got %0d want %0d", k, pos, m_pos); end
      t_exp += p;
    end
    send(1, n2);
    wait_until(n2 + 33);
    n_checks++; if (dut.shadow_period !== PW'(exp_period(1))) begin n_fail++; $display("FAIL ext_slow_shadow: got %0d want %0d", dut.shadow_period, exp_period(1)); end
    n_checks++; if (dut.shadow_dir !== 1'b0) begin n_fail++; $display("FAIL ext_slow_dir: got %b want 0", dut.shadow_dir); end
    wait_until(n2 + 33 + p + 1);
    n_checks++; if (dut.active_period !== PW'(exp_period(1))) begin n_fail++; $display("FAIL ext_slow_active: got %0d want %0d", dut.active_period, exp_period(1)); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL ext_running: got %b want 1", running); end
  endtask

  initial begin
    cmd_if.cmd_valid_i = 1'b0;
    cmd_if.cmd_rpm_i   = '0;
    @(negedge clk);
    test_reset();
    test_forward();
    test_reverse();
    test_boundary();
    test_random();
    test_stop();
    test_enable();
    test_reset_mid_div();
    test_extreme();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
